xor8_descrambler: RTL and testbench

- Byte-wide additive (synchronous-stream) descrambler. It is the receive end of the XOR8 scrambling path.
- Each accepted byte is XORed with an 8-bit keystream taken from an LFSR, using the structural XOR8 gate. The result is registered and the LFSR advances 8 steps.
- Valid/ready handshake on both sides, 1-entry output register. Sits between the byte deserializer and the frame parser.

---
 rtl/xor8_descrambler_pkg.sv | 28 ++
 rtl/xor8_descrambler_if.sv | 33 +++
 rtl/xor8_descrambler_lfsr_next8.sv | 24 ++
 rtl/xor8_descrambler_xor8.sv | 15 +
 rtl/xor8_descrambler.sv | 105 ++++++++++
 tb/tb_xor8_descrambler.sv | 196 +++++++++++++++++++
 6 files changed

// File: rtl/xor8_descrambler_pkg.sv
// Shared definitions for the XOR8 descrambler slice.
// Holds the LFSR tap positions, the default seed, the substitute that is loaded
// when a zero seed is requested, and two helpers: one LFSR single step and the
// seed guard that keeps the LFSR out of the all-zero lock-up state.
// Optional feature macro used by the top: XDS_CHECKSUM_EN.
package xor8_descrambler_pkg;

   localparam int TAP_A = 7;
   localparam int TAP_B = 5;
   localparam int TAP_C = 4;
   localparam int TAP_D = 3;

   localparam logic [7:0] DEFAULT_SEED  = 8'hFF;
   localparam logic [7:0] ZERO_SEED_SUB = 8'h01;

   // One Fibonacci step: feedback is shifted in at bit 0.
   function automatic logic [7:0] lfsr_step(input logic [7:0] s);
      logic fb;
      fb = s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
      return {s[6:0], fb};
   endfunction

   // An all-zero state would never leave zero, so a zero seed is replaced.
   function automatic logic [7:0] seed_guard(input logic [7:0] s);
      return (s == 8'h00) ? ZERO_SEED_SUB : s;
   endfunction

endpackage

// File: rtl/xor8_descrambler_if.sv
// Byte stream bus for the XOR8 descrambler.
// Carries the upstream side (in_data/in_valid/in_ready) and the downstream side
// (out_data/out_valid/out_ready) of the valid/ready handshakes.
//   master : the environment (drives input bytes and out_ready)
//   slave  : the descrambler (drives in_ready and the output register)
interface xor8_descrambler_if;

   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  out_data,
      input  out_valid,
      output out_ready
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output out_data,
      output out_valid,
      input  out_ready
   );

endinterface

// File: rtl/xor8_descrambler_lfsr_next8.sv
// xds_lfsr_next8: purely combinational LFSR advance by eight single steps.
// Built as eight chained step stages so that one accepted byte consumes one
// full keystream byte in a single cycle.
// Ports:
//   state_in  : current 8-bit LFSR state
//   state_out : state after eight single steps
module xds_lfsr_next8
   import xor8_descrambler_pkg::*;
(
   input  logic [7:0] state_in,
   output logic [7:0] state_out
);

   logic [7:0] stage [0:8];

   assign stage[0] = state_in;

   for (genvar i = 0; i < 8; i++) begin : g_step
      assign stage[i+1] = lfsr_step(stage[i]);
   end

   assign state_out = stage[8];

endmodule

// File: rtl/xor8_descrambler_xor8.sv
// XOR8: structural 8-bit XOR gate built from primitive xor cells.
// Ports:
//   a, b : 8-bit operands
//   y    : a ^ b
module XOR8 (
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] y
);

   for (genvar i = 0; i < 8; i++) begin : g_bit
      xor u_xor (y[i], a[i], b[i]);
   end

endmodule

// File: rtl/xor8_descrambler.sv
// xor8_descrambler: byte-wide additive descrambler, receive end of the XOR8
// scrambling path. Each accepted byte is XORed with the current LFSR state
// (the keystream byte), the result lands in a one-entry output register and
// the LFSR advances eight steps.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   sync     : one-cycle pulse, reloads LFSR and clears counter/checksum
//   bus      : slave side of the byte stream handshakes
//   byte_cnt : bytes accepted since reset/sync, saturating at all-ones
//   chk      : running XOR of output bytes (8'h00 unless built with it)
// Optional feature macro: XDS_CHECKSUM_EN (builds the checksum register).
module xor8_descrambler
   import xor8_descrambler_pkg::*;
#(
   parameter logic [7:0] SEED  = DEFAULT_SEED,
   parameter int         CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               sync,
   xor8_descrambler_if.slave  bus,
   output logic [CNT_W-1:0]   byte_cnt,
   output logic [7:0]         chk
);

   localparam logic [7:0] SEED_EFF = seed_guard(SEED);

   logic [7:0] lfsr_state;
   logic [7:0] key;
   logic [7:0] key_next;
   logic [7:0] descrambled;
   logic [7:0] out_data_r;
   logic       out_valid_r;
   logic       accept;

   // A pending output blocks new input unless it leaves this very cycle.
   assign bus.in_ready  = !out_valid_r || bus.out_ready;
   assign accept        = bus.in_valid && bus.in_ready;
   assign bus.out_data  = out_data_r;
   assign bus.out_valid = out_valid_r;

   // A sync arriving with a byte restarts the keystream on that byte.
   assign key = sync ? SEED_EFF : lfsr_state;

   XOR8 u_xor8 (
      .a (bus.in_data),
      .b (key),
      .y (descrambled)
   );

   xds_lfsr_next8 u_lfsr_next8 (
      .state_in  (key),
      .state_out (key_next)
   );

   // LFSR, output register and byte counter all move only on accept; a lone
   // sync reloads the LFSR and counter but leaves the output register alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_state  <= SEED_EFF;
         out_data_r  <= 8'h00;
         out_valid_r <= 1'b0;
         byte_cnt    <= '0;
      end else if (accept) begin
         lfsr_state  <= key_next;
         out_data_r  <= descrambled;
         out_valid_r <= 1'b1;
         if (sync) begin
            byte_cnt <= CNT_W'(1);
         end else if (!(&byte_cnt)) begin
            byte_cnt <= byte_cnt + CNT_W'(1);
         end
      end else begin
         if (sync) begin
            lfsr_state <= SEED_EFF;
            byte_cnt   <= '0;
         end
         if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
         end
      end
   end

`ifdef XDS_CHECKSUM_EN
   logic [7:0] chk_r;

   // Checksum folds in each byte as it is written to the output register;
   // sync restarts it, so sync with accept leaves just the new byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk_r <= 8'h00;
      end else if (accept) begin
         chk_r <= (sync ? 8'h00 : chk_r) ^ descrambled;
      end else if (sync) begin
         chk_r <= 8'h00;
      end
   end

   assign chk = chk_r;
`else
   assign chk = 8'h00;
`endif

endmodule

// File: tb/tb_xor8_descrambler.sv
// Testbench for xor8_descrambler: table-driven cycle vectors plus hand-written
// sequences for backpressure, async reset, zero seed and counter saturation.
// Expected values are hand-computed keystream bytes from seed FF:
// FF, 0B, C6; and from the zero-seed substitute 01: 01, 1C.
module tb_xor8_descrambler;

   logic        clk = 1'b0;
   logic        rst_n_a;
   logic        rst_n_b;
   logic        sync_a;
   logic        sync_b;
   logic [15:0] cnt_a;
   logic [1:0]  cnt_b;
   logic [7:0]  chk_a;
   logic [7:0]  chk_b;

   int testsRun  = 0;
   int failCount = 0;

`ifdef XDS_CHECKSUM_EN
   localparam bit CHK_ON = 1'b1;
`else
   localparam bit CHK_ON = 1'b0;
`endif

   xor8_descrambler_if bus_a ();
   xor8_descrambler_if bus_b ();

   xor8_descrambler #(.SEED(8'hFF), .CNT_W(16)) dut_a (
      .clk      (clk),
      .rst_n    (rst_n_a),
      .sync     (sync_a),
      .bus      (bus_a.slave),
      .byte_cnt (cnt_a),
      .chk      (chk_a)
   );

   xor8_descrambler #(.SEED(8'h00), .CNT_W(2)) dut_b (
      .clk      (clk),
      .rst_n    (rst_n_b),
      .sync     (sync_b),
      .bus      (bus_b.slave),
      .byte_cnt (cnt_b),
      .chk      (chk_b)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sync;
      logic [7:0]  data;
      logic        valid;
      logic        ready;
      logic        expReady;
      logic        expValid;
      logic [7:0]  expData;
      logic [15:0] expCnt;
      logic [7:0]  expChk;
   } vec_t;

   vec_t vecs [12];

   function automatic logic [7:0] chkExp(input logic [7:0] v);
      return CHK_ON ? v : 8'h00;
   endfunction

   // Drive one cycle worth of inputs on the default-seed instance at negedge.
   task automatic applyStimulus(input logic s, input logic [7:0] d,
                                input logic v, input logic r);
      @(negedge clk);
      sync_a          = s;
      bus_a.in_data   = d;
      bus_a.in_valid  = v;
      bus_a.out_ready = r;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Apply inputs, check in_ready before the edge, then registered outputs after.
   task automatic runCycle(input logic s, input logic [7:0] d, input logic v,
                           input logic r, input logic eReady, input logic eValid,
                           input logic [7:0] eData, input logic [15:0] eCnt,
                           input logic [7:0] eChk, input string tag);
      applyStimulus(s, d, v, r);
      #1;
      checkOutput({tag, ".in_ready"}, 32'(bus_a.in_ready), 32'(eReady));
      @(posedge clk);
      #1;
      checkOutput({tag, ".out_valid"}, 32'(bus_a.out_valid), 32'(eValid));
      checkOutput({tag, ".out_data"}, 32'(bus_a.out_data), 32'(eData));
      checkOutput({tag, ".byte_cnt"}, 32'(cnt_a), 32'(eCnt));
      checkOutput({tag, ".chk"}, 32'(chk_a), 32'(eChk));
   endtask

   task automatic stepB(input logic [7:0] d);
      @(negedge clk);
      bus_b.in_data  = d;
      bus_b.in_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // sync, data, valid, ready | in_ready, out_valid, out_data, byte_cnt, chk
      vecs[0]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 16'd1, chkExp(8'hFF)};
      vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h0B, 16'd2, chkExp(8'hF4)};
      vecs[2]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h0B, 16'd0, chkExp(8'h00)};
      vecs[3]  = '{1'b0, 8'hA6, 1'b1, 1'b1, 1'b1, 1'b1, 8'h59, 16'd1, chkExp(8'h59)};
      vecs[4]  = '{1'b0, 8'hA1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hAA, 16'd2, chkExp(8'hF3)};
      vecs[5]  = '{1'b0, 8'hB4, 1'b1, 1'b1, 1'b1, 1'b1, 8'h72, 16'd3, chkExp(8'h81)};
      vecs[6]  = '{1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 8'hC3, 16'd1, chkExp(8'hC3)};
      vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h0B, 16'd2, chkExp(8'hC8)};
      vecs[8]  = '{1'b0, 8'h77, 1'b0, 1'b1, 1'b1, 1'b0, 8'h0B, 16'd2, chkExp(8'hC8)};
      vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h0B, 16'd2, chkExp(8'hC8)};
      vecs[10] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h0B, 16'd0, chkExp(8'h00)};
      vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 16'd1, chkExp(8'hFF)};

      rst_n_a         = 1'b0;
      rst_n_b         = 1'b0;
      sync_a          = 1'b0;
      sync_b          = 1'b0;
      bus_a.in_data   = 8'h00;
      bus_a.in_valid  = 1'b0;
      bus_a.out_ready = 1'b1;
      bus_b.in_data   = 8'h00;
      bus_b.in_valid  = 1'b0;
      bus_b.out_ready = 1'b1;

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n_a = 1'b1;
      rst_n_b = 1'b1;
      #1;
      checkOutput("reset.out_valid", 32'(bus_a.out_valid), 32'h0);
      checkOutput("reset.out_data", 32'(bus_a.out_data), 32'h00);
      checkOutput("reset.byte_cnt", 32'(cnt_a), 32'h0);
      checkOutput("reset.chk", 32'(chk_a), 32'h00);
      checkOutput("reset.in_ready", 32'(bus_a.in_ready), 32'h1);

      for (int i = 0; i < 12; i++) begin
         runCycle(vecs[i].sync, vecs[i].data, vecs[i].valid, vecs[i].ready,
                  vecs[i].expReady, vecs[i].expValid, vecs[i].expData,
                  vecs[i].expCnt, vecs[i].expChk, $sformatf("vec%0d", i));
      end

      // Backpressure: first byte (FF) held three cycles, second uses key 0B.
      for (int i = 0; i < 3; i++) begin
         runCycle(1'b0, 8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 16'd1,
                  chkExp(8'hFF), $sformatf("stall%0d", i));
      end
      runCycle(1'b0, 8'h55, 1'b1, 1'b1, 1'b1, 1'b1, 8'h5E, 16'd2,
               chkExp(8'hA1), "release");
      runCycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5E, 16'd2,
               chkExp(8'hA1), "drain");

      // Third byte after sync uses key C6; hold it, then reset between edges.
      runCycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC6, 16'd3,
               chkExp(8'h67), "third");
      #2;
      rst_n_a = 1'b0;
      #1;
      checkOutput("async.out_valid", 32'(bus_a.out_valid), 32'h0);
      checkOutput("async.out_data", 32'(bus_a.out_data), 32'h00);
      checkOutput("async.byte_cnt", 32'(cnt_a), 32'h0);
      checkOutput("async.chk", 32'(chk_a), 32'h00);
      @(negedge clk);
      bus_a.in_valid = 1'b0;
      rst_n_a        = 1'b1;
      runCycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 16'd1,
               chkExp(8'hFF), "post_reset");

      // Zero seed becomes 01; 2-bit counter saturates at 3.
      stepB(8'h00);
      checkOutput("zseed.out_data0", 32'(bus_b.out_data), 32'h01);
      checkOutput("zseed.cnt0", 32'(cnt_b), 32'd1);
      stepB(8'h00);
      checkOutput("zseed.out_data1", 32'(bus_b.out_data), 32'h1C);
      checkOutput("zseed.cnt1", 32'(cnt_b), 32'd2);
      stepB(8'h00);
      checkOutput("zseed.cnt2", 32'(cnt_b), 32'd3);
      stepB(8'h00);
      checkOutput("zseed.cnt_sat", 32'(cnt_b), 32'd3);
      checkOutput("zseed.out_valid", 32'(bus_b.out_valid), 32'h1);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
